noc_vc_output_switch: RTL and testbench
=======================================

// Module: noc_vc_output_switch
// PURPOSE
//  Output stage of a NoC router port. It merges NUM_INPUTS input ports onto one output link with CHANNELS
//  virtual channels, using per-VC wormhole locking and per-VC round-robin input arbitration.
//  Each VC has its own FIFO. A round-robin VC scheduler drains the FIFOs onto the link under
//  per-VC downstream ready. Successor of the single-FIFO, externally-granted output switch:
//  arbitration is internal, VCs are buffered separately, and the input count is parametrised.
// PARAMETERS
//  NUM_INPUTS  5                    number of input ports
//  CHANNELS    Noc_VC_Channel       number of virtual channels (>=1)
//  DATA_WIDTH  128                  payload bits per flit
//  FLIT_WIDTH  DATA_WIDTH+2         flit = {tail, header, data}; bit DATA_WIDTH = header, DATA_WIDTH+1 = tail
//  FIFO_DEPTH  Noc_VC_Fifo_Depth    entries per VC FIFO (power of 2, >=2)
//  THRESHOLD   FIFO_DEPTH-2         almost-full level per VC
// PORTS
//  noc_clk           in   1                      clock; all logic on rising edge
//  noc_rst_n         in   1                      reset, synchronous, active-low
//  i_clear           in   1                      synchronous flush (same effect as reset)
//  i_valid           in   NUM_INPUTS             input i presents a flit
//  i_vc              in   NUM_INPUTS*VC_W        VC id per input; VC_W = max(1,$clog2(CHANNELS))
//  i_flit            in   NUM_INPUTS*FLIT_WIDTH  flit per input
//  o_ready           out  NUM_INPUTS             flit on input i accepted this cycle when i_valid[i]
//  o_valid           out  1                      output flit valid
//  o_vc              out  VC_W                   VC of output flit
//  o_flit            out  FLIT_WIDTH             output flit
//  i_vc_ready        in   CHANNELS               downstream can take a flit on VC v
//  o_vc_almost_full  out  CHANNELS               count[v] >= THRESHOLD
//  o_free            out  1                      any input handshake this cycle
// BEHAVIOUR
//  - Reset / i_clear (sampled at edge with noc_rst_n=0 or i_clear=1): all FIFOs empty, all VC locks free,
//    all RR pointers 0. Next cycle: o_valid=0, o_ready=0, o_vc_almost_full=0, o_free=0; o_vc/o_flit don't-care.
//  - VC lock per VC v: {locked, owner}. A header flit on v from input i may win only when v is unlocked.
//    Acceptance of a header sets owner=i and locked=1. Acceptance of the owner's tail clears the lock.
//    A header+tail flit acquires and releases in the same cycle (v stays unlocked).
//  - Input arbitration per VC: unlocked VC -> RR over inputs with i_valid & header & i_vc==v, starting at ptr[v].
//    On acceptance ptr[v] = winner+1 mod NUM_INPUTS. Locked VC -> only the owner is eligible, no
//    header required.
//  - Blocked cases (o_ready=0, flit held): non-header flit from a non-owner; header on a VC locked by another input.
//  - o_ready[i] = eligible & winner for i_vc[i] & count[i_vc[i]] < FIFO_DEPTH. This is combinational
//    from registered state; there is no pass-through on a same-cycle read from a full FIFO.
//  - Different VCs accept in parallel: up to min(NUM_INPUTS,CHANNELS) writes per cycle, at most one per VC.
//  - Latency: a flit accepted at cycle N is visible on o_flit at N+1 at the earliest. There is no bypass.
//  - Output scheduler: RR over VCs with count>0 & i_vc_ready[v], starting at vptr.
//    o_valid = any such VC; o_vc/o_flit = that VC's FIFO head.
//    Transfer occurs whenever o_valid=1, and on transfer vptr = o_vc+1 mod CHANNELS.
//    Downstream must accept whenever its i_vc_ready bit is high.
//  - Simultaneous write and read on the same VC: count unchanged and the pointers both advance.
//  - Counters are $clog2(FIFO_DEPTH+1) bits wide; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
//  - Order: flits within one VC leave in acceptance order; no ordering is guaranteed across VCs.
//  - o_free = |(i_valid & o_ready).
// STRUCTURE
//  - Noc_parameters package: add DATA_WIDTH-based flit field constants (HDR_BIT, TAIL_BIT),
//    typedef noc_vc_id_t, and typedef vc_lock_t {locked, owner}.
//  - Sub-module noc_rr_arbiter #(N): req[N], ptr -> one-hot gnt, gnt_idx.
//    Instantiated CHANNELS times for input arbitration and once (N=CHANNELS) for the output VC scheduler.
//  - The per-VC FIFO storage is a register array inside this block.
// TESTING (CHANNELS=2, NUM_INPUTS=5, FIFO_DEPTH=8, THRESHOLD=6)
//  1. Empty block; input 2 sends one header+tail flit on VC0 with data 0xA5 -> o_ready[2]=1 in cycle N.
//     At N+1: o_valid=1, o_vc=0, o_flit data=0xA5. VC0 is left unlocked.
//  2. Inputs 0 and 3 both send headers on VC1, ptr=0 -> input 0 wins and input 3 is held (o_ready[3]=0)
//     through input 0's 3-flit packet. Input 3's header is accepted the cycle after input 0's tail.
//  3. Input 1 (VC0) and input 4 (VC1) send 2-flit packets in the same cycle -> both o_ready=1 together.
//     Output order: VC0, VC1, VC0, VC1 across consecutive cycles.
//  4. i_vc_ready[0]=0; stream 9 body flits on VC0 from the lock owner.
//     -> o_vc_almost_full[0]=1 once count=6; o_ready drops on the 9th flit.
//     Then set i_vc_ready[0]=1 -> 8 flits drain in order, one per cycle.
//  5. Assert i_clear for 1 cycle mid-packet (VC1 locked by input 3) -> next cycle o_valid=0 and counts=0.
//     A header from input 0 on VC1 is then accepted immediately.
//  6. Assert noc_rst_n=0 for 1 cycle mid-stream -> same results as scenario 5.
//     Check that all outputs match their reset values the cycle after.

Source files
------------

// File: rtl/noc_vc_output_switch_pkg.sv
// Shared constants and types for the virtual-channel output switch.
// Flit layout is {tail, header, data}; field offsets are quoted for the default data width.
package noc_vc_output_switch_pkg;

    localparam int Noc_VC_Channel    = 2;
    localparam int Noc_VC_Fifo_Depth = 8;
    localparam int NOC_DATA_WIDTH    = 128;
    localparam int HDR_BIT           = NOC_DATA_WIDTH;
    localparam int TAIL_BIT          = NOC_DATA_WIDTH + 1;

    localparam int NOC_VC_ID_W = 4;
    localparam int NOC_OWNER_W = 8;

    typedef logic [NOC_VC_ID_W-1:0] noc_vc_id_t;

    typedef struct packed {
        logic                   locked;
        logic [NOC_OWNER_W-1:0] owner;
    } vc_lock_t;

endpackage

// File: rtl/noc_vc_output_switch_arbiter.sv
// Round-robin arbiter: the lowest requester at or above ptr wins, otherwise the lowest overall.
// Used for per-VC input arbitration and for the output VC scheduler.
module noc_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        gnt_idx = '0;
        // Later assignments override earlier ones, so the second pass has priority.
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) gnt_idx = PW'(j);
        end
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && j >= int'(ptr)) gnt_idx = PW'(j);
        end
        gnt = (|req) ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/noc_vc_output_switch.sv
// NoC router output stage: NUM_INPUTS inputs merged onto one link with CHANNELS virtual channels,
// each VC with its own wormhole lock, round-robin input arbiter and FIFO; an RR scheduler drains the VCs.
module noc_vc_output_switch
    import noc_vc_output_switch_pkg::*;
#(
    parameter int NUM_INPUTS = 5,
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int DATA_WIDTH = 128,
    parameter int FLIT_WIDTH = DATA_WIDTH + 2,
    parameter int FIFO_DEPTH = Noc_VC_Fifo_Depth,
    parameter int THRESHOLD  = FIFO_DEPTH - 2,
    parameter int VC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                             noc_clk,
    input  logic                             noc_rst_n,
    input  logic                             i_clear,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    input  logic [NUM_INPUTS*VC_W-1:0]       i_vc,
    input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] i_flit,
    output logic [NUM_INPUTS-1:0]            o_ready,
    output logic                             o_valid,
    output logic [VC_W-1:0]                  o_vc,
    output logic [FLIT_WIDTH-1:0]            o_flit,
    input  logic [CHANNELS-1:0]              i_vc_ready,
    output logic [CHANNELS-1:0]              o_vc_almost_full,
    output logic                             o_free
);

    localparam int IN_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int HDR_POS  = HDR_BIT - NOC_DATA_WIDTH + DATA_WIDTH;
    localparam int TAIL_POS = TAIL_BIT - NOC_DATA_WIDTH + DATA_WIDTH;

    logic srst;
    assign srst = !noc_rst_n || i_clear;

    logic [FLIT_WIDTH-1:0] in_flit [NUM_INPUTS];
    noc_vc_id_t            in_vc   [NUM_INPUTS];

    logic [NUM_INPUTS-1:0] ready_by_vc [CHANNELS];
    logic [FLIT_WIDTH-1:0] head_flit   [CHANNELS];
    logic [CHANNELS-1:0]   out_req;
    logic [CHANNELS-1:0]   out_gnt;
    logic [VC_W-1:0]       out_idx;
    logic [VC_W-1:0]       vptr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_in
            assign in_flit[gi] = i_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
            assign in_vc[gi]   = noc_vc_id_t'(i_vc[gi*VC_W +: VC_W]);
        end

        for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
            vc_lock_t              lock_reg;
            logic [IN_W-1:0]       in_ptr_reg;
            logic [CNT_W-1:0]      count_reg;
            logic [PTR_W-1:0]      wr_ptr_reg;
            logic [PTR_W-1:0]      rd_ptr_reg;
            logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];

            logic [NUM_INPUTS-1:0] in_req;
            logic [NUM_INPUTS-1:0] in_gnt;
            logic [IN_W-1:0]       gnt_idx;
            logic                  wr_en;
            logic                  rd_en;
            logic [FLIT_WIDTH-1:0] wr_flit;

            // A locked VC only listens to its owner; a free VC only to headers.
            always_comb begin
                in_req = '0;
                for (int i = 0; i < NUM_INPUTS; i++) begin
                    if (i_valid[i] && in_vc[i] == noc_vc_id_t'(gi)) begin
                        if (lock_reg.locked) in_req[i] = (lock_reg.owner == NOC_OWNER_W'(i));
                        else                 in_req[i] = in_flit[i][HDR_POS];
                    end
                end
            end

            noc_rr_arbiter #(.N(NUM_INPUTS), .PW(IN_W)) u_in_arb (
                .req     (in_req),
                .ptr     (in_ptr_reg),
                .gnt     (in_gnt),
                .gnt_idx (gnt_idx)
            );

            assign wr_en   = (|in_gnt) && (count_reg < CNT_W'(FIFO_DEPTH));
            assign rd_en   = out_gnt[gi];
            assign wr_flit = in_flit[gnt_idx];

            assign ready_by_vc[gi]      = wr_en ? in_gnt : '0;
            assign head_flit[gi]        = mem[rd_ptr_reg];
            assign out_req[gi]          = (count_reg != '0) && i_vc_ready[gi];
            assign o_vc_almost_full[gi] = (count_reg >= CNT_W'(THRESHOLD));

            always_ff @(posedge noc_clk) begin
                if (srst) begin
                    lock_reg   <= '0;
                    in_ptr_reg <= '0;
                    count_reg  <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        in_ptr_reg <= (gnt_idx == IN_W'(NUM_INPUTS - 1)) ? '0 : gnt_idx + 1'b1;
                        // A single-flit packet (header+tail) never takes the lock.
                        if (!lock_reg.locked && wr_flit[HDR_POS] && !wr_flit[TAIL_POS]) begin
                            lock_reg.locked <= 1'b1;
                            lock_reg.owner  <= NOC_OWNER_W'(gnt_idx);
                        end else if (lock_reg.locked && wr_flit[TAIL_POS]) begin
                            lock_reg.locked <= 1'b0;
                        end
                    end
                    if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (wr_en && !rd_en)      count_reg <= count_reg + 1'b1;
                    else if (!wr_en && rd_en) count_reg <= count_reg - 1'b1;
                end
            end

            always_ff @(posedge noc_clk) begin
                if (wr_en) mem[wr_ptr_reg] <= wr_flit;
            end
        end
    endgenerate

    always_comb begin
        o_ready = '0;
        for (int v = 0; v < CHANNELS; v++) o_ready = o_ready | ready_by_vc[v];
    end

    assign o_free = |(i_valid & o_ready);

    noc_rr_arbiter #(.N(CHANNELS), .PW(VC_W)) u_vc_sched (
        .req     (out_req),
        .ptr     (vptr_reg),
        .gnt     (out_gnt),
        .gnt_idx (out_idx)
    );

    assign o_valid = |out_req;
    assign o_vc    = out_idx;
    assign o_flit  = head_flit[out_idx];

    always_ff @(posedge noc_clk) begin
        if (srst)         vptr_reg <= '0;
        else if (o_valid) vptr_reg <= (out_idx == VC_W'(CHANNELS - 1)) ? '0 : out_idx + 1'b1;
    end

endmodule

// File: tb/tb_noc_vc_output_switch.sv
// Bench for noc_vc_output_switch: per-input packet queues drive the DUT, a reference model predicts
// acceptances and pushes expected flits per VC, and a monitor pops them as the DUT emits flits.
module tb_noc_vc_output_switch;

    localparam int NI    = 5;
    localparam int CH    = 2;
    localparam int DW    = 32;
    localparam int FW    = DW + 2;
    localparam int DEPTH = 8;
    localparam int THR   = 6;
    localparam int VW    = 1;

    logic              noc_clk   = 1'b0;
    logic              noc_rst_n = 1'b0;
    logic              i_clear   = 1'b0;
    logic [NI-1:0]     i_valid   = '0;
    logic [NI*VW-1:0]  i_vc      = '0;
    logic [NI*FW-1:0]  i_flit    = '0;
    logic [NI-1:0]     o_ready;
    logic              o_valid;
    logic [VW-1:0]     o_vc;
    logic [FW-1:0]     o_flit;
    logic [CH-1:0]     i_vc_ready = '0;
    logic [CH-1:0]     o_vc_almost_full;
    logic              o_free;

    always #5 noc_clk = ~noc_clk;

    noc_vc_output_switch #(
        .NUM_INPUTS (NI), .CHANNELS (CH), .DATA_WIDTH (DW), .FLIT_WIDTH (FW),
        .FIFO_DEPTH (DEPTH), .THRESHOLD (THR), .VC_W (VW)
    ) dut (
        .noc_clk          (noc_clk),
        .noc_rst_n        (noc_rst_n),
        .i_clear          (i_clear),
        .i_valid          (i_valid),
        .i_vc             (i_vc),
        .i_flit           (i_flit),
        .o_ready          (o_ready),
        .o_valid          (o_valid),
        .o_vc             (o_vc),
        .o_flit           (o_flit),
        .i_vc_ready       (i_vc_ready),
        .o_vc_almost_full (o_vc_almost_full),
        .o_free           (o_free)
    );

    typedef struct {
        int            vc;
        logic [FW-1:0] flit;
    } item_t;

    item_t         in_q  [NI][$];
    logic [FW-1:0] exp_q [CH][$];

    int n_vec = 0;
    int n_err = 0;

    bit            m_locked [CH];
    int            m_owner  [CH];
    int            m_iptr   [CH];
    int            m_vptr   = 0;
    bit            popped   = 0;
    int            popped_vc = 0;
    bit            post_rst = 0;
    logic [NI-1:0] acc      = '0;

    bit            bubble_en  = 0;
    logic [CH-1:0] force_mask = '1;
    logic [CH-1:0] force_val  = '1;
    bit            clear_req  = 0;
    bit            rst_req    = 1;

    function automatic void check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [FW-1:0] mk(input bit tail, input bit hdr, input logic [DW-1:0] data);
        return {tail, hdr, data};
    endfunction

    function automatic void push_pkt(input int i, input int vc, input int len);
        item_t it;
        it.vc = vc;
        for (int k = 0; k < len; k++) begin
            it.flit = mk(k == len - 1, k == 0, DW'($urandom));
            in_q[i].push_back(it);
        end
    endfunction

    function automatic bit idle();
        for (int i = 0; i < NI; i++) if (in_q[i].size() != 0) return 0;
        for (int v = 0; v < CH; v++) if (exp_q[v].size() != 0) return 0;
        return 1;
    endfunction

    // Driver: retire accepted flits, apply any requested flush, present each input queue's head.
    always @(posedge noc_clk) begin
        #1;
        for (int i = 0; i < NI; i++)
            if (i_valid[i] && acc[i] && in_q[i].size() > 0) void'(in_q[i].pop_front());
        noc_rst_n = !rst_req;
        i_clear   = clear_req;
        if (rst_req || clear_req) begin
            for (int i = 0; i < NI; i++) in_q[i].delete();
            rst_req   = 0;
            clear_req = 0;
        end
        for (int i = 0; i < NI; i++) begin
            if (in_q[i].size() > 0 && !(bubble_en && $urandom_range(0, 3) == 0)) begin
                i_valid[i]          = 1'b1;
                i_vc[i*VW +: VW]    = VW'(in_q[i][0].vc);
                i_flit[i*FW +: FW]  = in_q[i][0].flit;
            end else begin
                i_valid[i] = 1'b0;
            end
        end
        for (int v = 0; v < CH; v++)
            i_vc_ready[v] = force_mask[v] ? force_val[v] : 1'($urandom_range(0, 1));
    end

    // Monitor: RR over VCs holding data with downstream ready; pops the expected head.
    always @(negedge noc_clk) begin
        int sel;
        popped = 0;
        if (post_rst) begin
            check("rst_o_valid", FW'(o_valid), '0);
            check("rst_o_ready", FW'(o_ready), '0);
            check("rst_almost_full", FW'(o_vc_almost_full), '0);
            check("rst_o_free", FW'(o_free), '0);
            post_rst = 0;
        end
        sel = -1;
        for (int k = 0; k < CH; k++)
            if (sel < 0 && exp_q[(m_vptr + k) % CH].size() > 0 && i_vc_ready[(m_vptr + k) % CH])
                sel = (m_vptr + k) % CH;
        check("o_valid", FW'(o_valid), FW'(sel >= 0));
        if (sel >= 0) begin
            check("o_vc", FW'(o_vc), FW'(sel));
            check("o_flit", o_flit, exp_q[sel][0]);
            void'(exp_q[sel].pop_front());
            m_vptr    = (sel + 1) % CH;
            popped    = 1;
            popped_vc = sel;
        end
    end

    // Reference model: wormhole locks and RR input selection, evaluated after the monitor.
    always begin
        logic [NI-1:0] exp_ready;
        logic [FW-1:0] f;
        int cnt, win, idx;
        @(negedge noc_clk);
        #1;
        if (!noc_rst_n || i_clear) begin
            for (int v = 0; v < CH; v++) begin
                m_locked[v] = 0;
                m_iptr[v]   = 0;
                exp_q[v].delete();
            end
            m_vptr   = 0;
            acc      = '0;
            post_rst = 1;
        end else begin
            exp_ready = '0;
            for (int v = 0; v < CH; v++) begin
                cnt = exp_q[v].size() + ((popped && popped_vc == v) ? 1 : 0);
                check($sformatf("almost_full[%0d]", v), FW'(o_vc_almost_full[v]), FW'(cnt >= THR));
                win = -1;
                for (int k = 0; k < NI; k++) begin
                    idx = (m_iptr[v] + k) % NI;
                    f   = i_flit[idx*FW +: FW];
                    if (win < 0 && i_valid[idx] && int'(i_vc[idx*VW +: VW]) == v &&
                        (m_locked[v] ? (m_owner[v] == idx) : f[DW]))
                        win = idx;
                end
                if (win >= 0 && cnt < DEPTH) begin
                    f = i_flit[win*FW +: FW];
                    exp_ready[win] = 1'b1;
                    exp_q[v].push_back(f);
                    m_iptr[v] = (win + 1) % NI;
                    if (f[DW+1]) m_locked[v] = 0;
                    else if (f[DW] && !m_locked[v]) begin
                        m_locked[v] = 1;
                        m_owner[v]  = win;
                    end
                end
            end
            check("o_ready", FW'(o_ready), FW'(exp_ready));
            check("o_free", FW'(o_free), FW'(|(i_valid & exp_ready)));
            acc = exp_ready;
        end
    end

    task automatic next_cycle();
        @(posedge noc_clk);
        @(negedge noc_clk);
        #3;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (!idle() && t < budget) begin
            @(negedge noc_clk);
            #3;
            t++;
        end
        check("idle_timeout", FW'(t >= budget), '0);
    endtask

    task automatic flush_check(input bit use_rst);
        item_t it;
        push_pkt(3, 1, 8);
        repeat (3) next_cycle();
        if (use_rst) rst_req = 1;
        else         clear_req = 1;
        next_cycle();
        next_cycle();
        check("flush_o_valid", FW'(o_valid), '0);
        it.vc   = 1;
        it.flit = mk(0, 1, DW'(32'h0C1E));
        in_q[0].push_back(it);
        it.flit = mk(1, 0, DW'(32'h0C1F));
        in_q[0].push_back(it);
        next_cycle();
        check("flush_hdr_ready", FW'(o_ready[0]), FW'(1'b1));
        wait_idle(60);
    endtask

    initial begin
        item_t it;
        repeat (3) @(negedge noc_clk);
        #3;

        // Single header+tail flit from input 2 on VC0, visible the cycle after acceptance.
        it.vc   = 0;
        it.flit = mk(1, 1, DW'(32'hA5));
        in_q[2].push_back(it);
        next_cycle();
        check("s1_ready", FW'(o_ready[2]), FW'(1'b1));
        next_cycle();
        check("s1_valid", FW'(o_valid), FW'(1'b1));
        check("s1_data", FW'(o_flit[DW-1:0]), FW'(32'hA5));
        wait_idle(40);

        // Two headers competing for VC1: input 0 wins, input 3 waits for the tail.
        push_pkt(0, 1, 3);
        push_pkt(3, 1, 2);
        next_cycle();
        check("s2_ready", FW'(o_ready & 5'b01001), FW'(5'b00001));
        wait_idle(40);

        // Different VCs accept in parallel.
        push_pkt(1, 0, 2);
        push_pkt(4, 1, 2);
        next_cycle();
        check("s3_ready", FW'(o_ready & 5'b10010), FW'(5'b10010));
        wait_idle(40);

        // VC0 blocked downstream: fill to full, then drain.
        force_val[0] = 1'b0;
        it.vc = 0;
        it.flit = mk(0, 1, DW'(32'h100));
        in_q[1].push_back(it);
        for (int k = 0; k < 9; k++) begin
            it.flit = mk(0, 0, DW'(32'h200 + k));
            in_q[1].push_back(it);
        end
        it.flit = mk(1, 0, DW'(32'h300));
        in_q[1].push_back(it);
        repeat (14) next_cycle();
        check("s4_almost_full", FW'(o_vc_almost_full[0]), FW'(1'b1));
        check("s4_blocked", FW'(o_ready[1]), FW'(1'b0));
        force_val[0] = 1'b1;
        wait_idle(60);

        flush_check(0);
        flush_check(1);

        // Random traffic with bubbles and random downstream back-pressure.
        bubble_en  = 1;
        force_mask = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge noc_clk);
            #3;
            for (int i = 0; i < NI; i++)
                if (in_q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(i, int'($urandom_range(0, CH - 1)), int'($urandom_range(1, 4)));
        end
        force_mask = '1;
        force_val  = '1;
        wait_idle(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
